tiamc1_analog_in: RTL and testbench
===================================

Name: tiamc1_analog_in

Overview:
Multi-channel analog controller conditioner for the TIA-MC1 core. Converts HPS joystick-analog, paddle and spinner inputs into per-channel absolute position registers of parametrised width. The CPU I/O decoder samples these through a strobe/valid read port. Sits between hps_io outputs and the tiamc1 input port logic, and generalises the single-player, fixed 8-bit analog path to N channels with rate integration, saturation and wrap rules.

Parameters:
CHANNELS, 2, number of independent player channels (1..4)
POS_W, 8, position register width in bits (6..12)
JOY_SHIFT, 3, arithmetic right shift applied to the joystick X axis before integration
DEADZONE, 8, joystick magnitude treated as zero (used only with ANALOG_DEADZONE_EN)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_mode  in  2  0=joystick, 1=paddle, 2=spinner, 3=reserved (acts as paddle)
cfg_invert  in  1  1=invert axis direction
vblank  in  1  video VBlank level; rising edge is the integration tick
joy_analog  in  16*CHANNELS  per channel: [7:0] signed X, [15:8] signed Y (Y unused)
paddle  in  8*CHANNELS  per channel: unsigned paddle position
spinner  in  9*CHANNELS  per channel: [7:0] signed delta, [8] toggles on each new sample
rd_sel  in  2  channel index to read
rd_strobe  in  1  read request, one cycle
rd_data  out  POS_W  sampled position
rd_valid  out  1  one-cycle pulse, rd_data valid
pos_all  out  POS_W*CHANNELS  live position registers (debug/LED)

Behaviour:
- Reset: every pos = CENTER = 2^(POS_W-1); rd_data=0; rd_valid=0; vblank_q=1 (no spurious edge); spin_tog_q captured from input on the first cycle after reset, with no delta applied.
- Mode change (cfg_mode differs from its registered copy): all pos = CENTER on the next cycle. Takes priority over any update in the same cycle.
- Joystick mode: on the vblank rising edge (vblank & ~vblank_q), d = X >>> JOY_SHIFT, negated if cfg_invert. Sign-extend d and pos to POS_W+2, add, clamp to [0, 2^POS_W-1]. Saturating, never wraps. Update lands in the cycle after the edge.
- Paddle mode: combinational source registered every cycle. p = paddle<<(POS_W-8) if POS_W>=8, else paddle>>(8-POS_W). If cfg_invert, p = ~p (POS_W bits). Latency 1 cycle.
- Spinner mode: when spinner[8] != spin_tog_q, pos += sign-extended delta (negated if cfg_invert), modulo 2^POS_W (wraps). spin_tog_q is updated in every mode, so a mode switch never replays a stale delta.
- Read port: rd_strobe at cycle N latches pos[rd_sel] at cycle N. rd_data and rd_valid=1 appear at N+1; rd_valid is 0 otherwise. If a position update occurs in the same cycle N, the pre-update value is returned. rd_sel >= CHANNELS returns CENTER. Back-to-back strobes are each served, one result per cycle.
- Reset asserted mid-read: rd_valid is forced to 0 and the pending result is discarded.
- Negation of -128 with JOY_SHIFT=0 yields +128 (computed at 9 bits, not truncated).

Optional Feature:
ANALOG_DEADZONE_EN: when defined, joystick X with |X| < DEADZONE contributes d=0, evaluated before the shift. When undefined, no deadzone logic is generated and DEADZONE is ignored.

Decomposition:
- Package tiamc1_analog_pkg: mode enum (MODE_JOY, MODE_PADDLE, MODE_SPIN, MODE_RSVD), CENTER function of POS_W, saturating-add function.
- One sub-module, tiamc1_analog_chan: the per-channel position register, toggle/edge tracking and mode arithmetic, instantiated CHANNELS times in a generate loop. The top module holds the mode-change detector, vblank edge detector and read mux.

Test Plan:
- Reset, POS_W=8: all pos=128; strobe rd_sel=0 -> rd_valid next cycle, rd_data=128.
- Joystick, X=+64, JOY_SHIFT=3, 20 vblank edges -> pos 128 -> 255 after 16 edges, then stays 255. X=-128, no invert -> 1 decrements by 16 per edge, clamps at 0.
- Paddle, POS_W=10, paddle=0xA5 -> pos=0x294 after 1 cycle. With cfg_invert=1 -> 0x16B.
- Spinner, delta=+100: toggle 3 times -> 128+300 mod 256 = 172. Change the delta without a toggle -> pos unchanged.
- Mode change joystick->spinner in the same cycle as a vblank edge -> pos=128, no increment. A strobe in that cycle returns the pre-change value.
- ANALOG_DEADZONE_EN, DEADZONE=8, X=+7 over 5 edges -> pos stays 128. X=+8 -> +1 per edge.

Source files
------------

// File: rtl/tiamc1_analog_pkg.sv
// Shared types and arithmetic helpers for the TIA-MC1 analog input conditioner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package tiamc1_analog_pkg;

  typedef enum logic [1:0] {
    MODE_JOY    = 2'd0,
    MODE_PADDLE = 2'd1,
    MODE_SPIN   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  // Mid-scale position for a register of pos_w bits (pos_w <= 12).
  function automatic logic [11:0] center(input int pos_w);
    return 12'(1) << (pos_w - 1);
  endfunction

  // Unsigned position plus signed rate, clamped to [0, 2^pos_w-1].
  // The sum is formed two bits wider than the position so it never wraps.
  function automatic logic [11:0] sat_add(input logic [11:0] pos,
                                          input logic signed [8:0] d,
                                          input int pos_w);
    logic signed [13:0] sum;
    logic signed [13:0] lim;
    sum = $signed({2'b00, pos}) + $signed({{5{d[8]}}, d});
    lim = 14'((1 << pos_w) - 1);
    if (sum < 0)
      return '0;
    else if (sum > lim)
      return lim[11:0];
    else
      return sum[11:0];
  endfunction

endpackage

// File: rtl/tiamc1_analog_chan.sv
// One player channel: position register with joystick/paddle/spinner arithmetic.
// Latency: 1 cycle from qualifying input (tick, paddle, spinner toggle) to pos.
// Backpressure: none; updates are applied unconditionally when they occur.
// Optional feature macro: ANALOG_DEADZONE_EN (joystick deadzone before the shift).
module tiamc1_analog_chan
  import tiamc1_analog_pkg::*;
#(
  parameter int POS_W     = 8,
  parameter int JOY_SHIFT = 3,
  parameter int DEADZONE  = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             invert,
  input  logic             tick,
  input  logic             clear,
  input  logic [7:0]       joy_x,
  input  logic [7:0]       paddle,
  input  logic [8:0]       spinner,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] CENTER_V = POS_W'(center(POS_W));

  logic signed [7:0] joy_s;
  logic signed [7:0] joy_src;
  logic signed [8:0] joy_d;
  logic [POS_W-1:0]  joy_next;
  logic [POS_W-1:0]  pad_p;
  logic [POS_W-1:0]  pad_v;
  logic signed [8:0] spin_d;
  logic [13:0]       spin_sum;
  logic [POS_W-1:0]  spin_next;
  logic              tog_q;
  logic              primed;
`ifdef ANALOG_DEADZONE_EN
  logic [8:0]        joy_ext;
  logic [8:0]        joy_mag;
`endif

  assign joy_s = joy_x;

  // Joystick rate: optional deadzone, arithmetic shift, then 9-bit negate so -128 becomes +128.
  always_comb begin
    joy_src = joy_s >>> JOY_SHIFT;
`ifdef ANALOG_DEADZONE_EN
    joy_ext = {joy_s[7], joy_s};
    joy_mag = joy_ext[8] ? (~joy_ext + 9'd1) : joy_ext;
    if (joy_mag < 9'(DEADZONE))
      joy_src = '0;
`endif
    joy_d = invert ? -{joy_src[7], joy_src} : {joy_src[7], joy_src};
  end

  assign joy_next = POS_W'(sat_add(12'(pos), joy_d, POS_W));

  // Paddle scaling to the position width: left-align wide registers, truncate narrow ones.
  generate
    if (POS_W >= 8) begin : g_pad_wide
      assign pad_p = POS_W'(paddle) << (POS_W - 8);
    end else begin : g_pad_narrow
      assign pad_p = POS_W'(paddle >> (8 - POS_W));
    end
  endgenerate

  assign pad_v = invert ? ~pad_p : pad_p;

  // Spinner delta is applied modulo 2^POS_W, so the position wraps freely.
  always_comb begin
    spin_d    = invert ? -{spinner[7], spinner[7:0]} : {spinner[7], spinner[7:0]};
    spin_sum  = {{(14-POS_W){1'b0}}, pos} + {{5{spin_d[8]}}, spin_d};
    spin_next = spin_sum[POS_W-1:0];
  end

  // Position register; the toggle copy follows the input in every mode so no stale delta replays.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pos    <= CENTER_V;
      tog_q  <= 1'b0;
      primed <= 1'b0;
    end else begin
      tog_q  <= spinner[8];
      primed <= 1'b1;
      if (clear) begin
        pos <= CENTER_V;
      end else begin
        case (mode_t'(mode))
          MODE_JOY:  if (tick) pos <= joy_next;
          MODE_SPIN: if (primed && (spinner[8] != tog_q)) pos <= spin_next;
          default:   pos <= pad_v;
        endcase
      end
    end
  end

endmodule

// File: rtl/tiamc1_analog_in.sv
// Multi-channel analog conditioner: mode-change and vblank edge detection, per-channel positions, read port.
// Latency: position updates 1 cycle after their trigger; rd_data/rd_valid 1 cycle after rd_strobe.
// Backpressure: none; every strobe is served, one result per cycle.
// Optional feature macro: ANALOG_DEADZONE_EN (joystick deadzone, see tiamc1_analog_chan).
module tiamc1_analog_in
  import tiamc1_analog_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int POS_W     = 8,
  parameter int JOY_SHIFT = 3,
  parameter int DEADZONE  = 8
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [1:0]                cfg_mode,
  input  logic                      cfg_invert,
  input  logic                      vblank,
  input  logic [16*CHANNELS-1:0]    joy_analog,
  input  logic [8*CHANNELS-1:0]     paddle,
  input  logic [9*CHANNELS-1:0]     spinner,
  input  logic [1:0]                rd_sel,
  input  logic                      rd_strobe,
  output logic [POS_W-1:0]          rd_data,
  output logic                      rd_valid,
  output logic [POS_W*CHANNELS-1:0] pos_all
);

  localparam logic [POS_W-1:0] CENTER_V = POS_W'(center(POS_W));

  logic [1:0]            mode_q;
  logic                  vblank_q;
  logic                  mode_chg;
  logic                  tick;
  logic [POS_W-1:0]      sel_pos;
  logic [8*CHANNELS-1:0] unused_joy_y;

  assign mode_chg = (cfg_mode != mode_q);
  assign tick     = vblank & ~vblank_q;

  // Registered copies of mode and vblank; vblank_q resets high so reset never fakes an edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode_q   <= cfg_mode;
      vblank_q <= 1'b1;
    end else begin
      mode_q   <= cfg_mode;
      vblank_q <= vblank;
    end
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      assign unused_joy_y[8*c +: 8] = joy_analog[16*c+8 +: 8];

      tiamc1_analog_chan #(
        .POS_W     (POS_W),
        .JOY_SHIFT (JOY_SHIFT),
        .DEADZONE  (DEADZONE)
      ) u_chan (
        .clk_sys (clk_sys),
        .reset   (reset),
        .mode    (cfg_mode),
        .invert  (cfg_invert),
        .tick    (tick),
        .clear   (mode_chg),
        .joy_x   (joy_analog[16*c +: 8]),
        .paddle  (paddle[8*c +: 8]),
        .spinner (spinner[9*c +: 9]),
        .pos     (pos_all[POS_W*c +: POS_W])
      );
    end
  endgenerate

  // Read mux over the current (pre-update) registers; unpopulated channels read as center.
  always_comb begin
    sel_pos = CENTER_V;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_sel == 2'(c))
        sel_pos = pos_all[POS_W*c +: POS_W];
    end
  end

  // Read port register: one-cycle valid pulse per strobe, cleared by reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_strobe;
      if (rd_strobe)
        rd_data <= sel_pos;
    end
  end

endmodule

// File: tb/tb_tiamc1_analog_in.sv
// Self-checking bench: two instances (8-bit and 10-bit positions) share all inputs.
// Read results are checked through per-instance scoreboard queues.
module tb_tiamc1_analog_in;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cfg_mode = 2'd0;
  logic        cfg_invert = 1'b0;
  logic        vblank = 1'b0;
  logic [7:0]  joy_x [2];
  logic [7:0]  pad_in [2];
  logic [8:0]  spin_in [2];
  logic [1:0]  rd_sel = 2'd0;
  logic        rd_strobe = 1'b0;

  logic [31:0] joy_analog;
  logic [15:0] paddle;
  logic [17:0] spinner;
  assign joy_analog = {8'h00, joy_x[1], 8'h00, joy_x[0]};
  assign paddle     = {pad_in[1], pad_in[0]};
  assign spinner    = {spin_in[1], spin_in[0]};

  logic [7:0]  rd_data8;
  logic        rd_valid8;
  logic [15:0] pos_all8;
  logic [9:0]  rd_data10;
  logic        rd_valid10;
  logic [19:0] pos_all10;

  int errors = 0;
  int checks = 0;
  int exp8 [2];
  int exp10 [2];
  int q8 [$];
  int q10 [$];

  tiamc1_analog_in #(.CHANNELS(2), .POS_W(8), .JOY_SHIFT(3), .DEADZONE(8)) dut8 (
    .clk_sys(clk_sys), .reset(reset), .cfg_mode(cfg_mode), .cfg_invert(cfg_invert),
    .vblank(vblank), .joy_analog(joy_analog), .paddle(paddle), .spinner(spinner),
    .rd_sel(rd_sel), .rd_strobe(rd_strobe), .rd_data(rd_data8), .rd_valid(rd_valid8),
    .pos_all(pos_all8));

  tiamc1_analog_in #(.CHANNELS(2), .POS_W(10), .JOY_SHIFT(3), .DEADZONE(8)) dut10 (
    .clk_sys(clk_sys), .reset(reset), .cfg_mode(cfg_mode), .cfg_invert(cfg_invert),
    .vblank(vblank), .joy_analog(joy_analog), .paddle(paddle), .spinner(spinner),
    .rd_sel(rd_sel), .rd_strobe(rd_strobe), .rd_data(rd_data10), .rd_valid(rd_valid10),
    .pos_all(pos_all10));

  always #5 clk_sys = ~clk_sys;

  initial begin
    #400000;
    $display("FAIL timeout: run did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Scoreboard consumers: every valid pulse must match the oldest pending expectation.
  always @(negedge clk_sys) begin
    if (rd_valid8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL rd8_unexpected: rd_valid=1 data=%0d, required no valid", rd_data8);
      end else begin
        int e;
        e = q8.pop_front();
        if (rd_data8 !== 8'(e)) begin
          errors++;
          $display("FAIL rd8_data: got %0d, required %0d", rd_data8, e);
        end
      end
    end
    if (rd_valid10) begin
      checks++;
      if (q10.size() == 0) begin
        errors++;
        $display("FAIL rd10_unexpected: rd_valid=1 data=%0d, required no valid", rd_data10);
      end else begin
        int e;
        e = q10.pop_front();
        if (rd_data10 !== 10'(e)) begin
          errors++;
          $display("FAIL rd10_data: got %0d, required %0d", rd_data10, e);
        end
      end
    end
  end

  // ---------------- model helpers ----------------
  function automatic int clampw(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic int wrapw(int v, int w);
    int m;
    m = 1 << w;
    return ((v % m) + m) % m;
  endfunction

  function automatic int sx8(logic [7:0] b);
    return (b >= 8'd128) ? int'(b) - 256 : int'(b);
  endfunction

  function automatic int joy_rate(logic [7:0] xb, bit inv);
    int x;
    int d;
    x = sx8(xb);
    d = (x >= 0) ? (x / 8) : -((-x + 7) / 8);
`ifdef ANALOG_DEADZONE_EN
    if (((x < 0) ? -x : x) < 8) d = 0;
`endif
    return inv ? -d : d;
  endfunction

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_center();
    for (int c = 0; c < 2; c++) begin
      exp8[c]  = 128;
      exp10[c] = 512;
    end
  endtask

  task automatic model_paddle();
    for (int c = 0; c < 2; c++) begin
      exp8[c]  = cfg_invert ? 255 - int'(pad_in[c]) : int'(pad_in[c]);
      exp10[c] = cfg_invert ? 1023 - int'(pad_in[c]) * 4 : int'(pad_in[c]) * 4;
    end
  endtask

  task automatic check_pos(string name);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (pos_all8[8*c +: 8] !== 8'(exp8[c])) begin
        errors++;
        $display("FAIL %s pos8[%0d]: got %0d, required %0d", name, c, pos_all8[8*c +: 8], exp8[c]);
      end
      checks++;
      if (pos_all10[10*c +: 10] !== 10'(exp10[c])) begin
        errors++;
        $display("FAIL %s pos10[%0d]: got %0d, required %0d", name, c, pos_all10[10*c +: 10], exp10[c]);
      end
    end
  endtask

  // One-cycle strobe; expectation taken from the model before any same-cycle update.
  task automatic rd(input logic [1:0] sel);
    rd_sel    = sel;
    rd_strobe = 1'b1;
    q8.push_back((sel < 2) ? exp8[sel] : 128);
    q10.push_back((sel < 2) ? exp10[sel] : 512);
    cyc();
    rd_strobe = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m, string name);
    cfg_mode = m;
    cyc();
    set_center();
    check_pos(name);
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    cyc();
    if (cfg_mode == 2'd0) begin
      for (int c = 0; c < 2; c++) begin
        exp8[c]  = clampw(exp8[c]  + joy_rate(joy_x[c], cfg_invert), 8);
        exp10[c] = clampw(exp10[c] + joy_rate(joy_x[c], cfg_invert), 10);
      end
    end
    cyc();
    vblank = 1'b0;
    cyc();
  endtask

  task automatic spin_flip();
    for (int c = 0; c < 2; c++) spin_in[c][8] = ~spin_in[c][8];
    cyc();
    for (int c = 0; c < 2; c++) begin
      int d;
      d = sx8(spin_in[c][7:0]);
      if (cfg_invert) d = -d;
      exp8[c]  = wrapw(exp8[c] + d, 8);
      exp10[c] = wrapw(exp10[c] + d, 10);
    end
  endtask

  task automatic check_no_valid(string name);
    checks++;
    if (rd_valid8 !== 1'b0 || rd_valid10 !== 1'b0) begin
      errors++;
      $display("FAIL %s: rd_valid8=%0b rd_valid10=%0b, required 0", name, rd_valid8, rd_valid10);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    set_center();
    check_pos("reset");
    check_no_valid("reset_valid");
    checks++;
    if (rd_data8 !== 8'd0 || rd_data10 !== 10'd0) begin
      errors++;
      $display("FAIL reset_rd_data: got %0d/%0d, required 0/0", rd_data8, rd_data10);
    end
    rd(2'd0);
    rd(2'd3);
    cyc();
    check_no_valid("valid_after_reads");
  endtask

  task automatic test_joystick();
    joy_x[0] = 8'h40;
    joy_x[1] = 8'h80;
    for (int i = 0; i < 20; i++) begin
      vb_pulse();
      check_pos("joy_edge");
    end
    cfg_invert = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vb_pulse();
      check_pos("joy_invert");
    end
    cfg_invert = 1'b0;
  endtask

  task automatic test_deadzone();
    set_mode(2'd1, "dz_to_paddle");
    set_mode(2'd0, "dz_to_joy");
    joy_x[0] = 8'h07;
    joy_x[1] = 8'hF9;
    for (int i = 0; i < 5; i++) begin
      vb_pulse();
      check_pos("dz_small");
    end
    joy_x[0] = 8'h08;
    joy_x[1] = 8'hF8;
    for (int i = 0; i < 3; i++) begin
      vb_pulse();
      check_pos("dz_edge");
    end
  endtask

  task automatic test_paddle();
    pad_in[0] = 8'h00;
    pad_in[1] = 8'h00;
    set_mode(2'd1, "pad_mode_change");
    cyc();
    model_paddle();
    check_pos("pad_zero");
    pad_in[0] = 8'hA5;
    pad_in[1] = 8'h3C;
    cyc();
    model_paddle();
    check_pos("pad_a5");
    cfg_invert = 1'b1;
    cyc();
    model_paddle();
    check_pos("pad_invert");
    rd(2'd0);
    rd(2'd1);
    cfg_invert = 1'b0;
    cyc();
    model_paddle();
    cfg_mode = 2'd3;
    cyc();
    set_center();
    cyc();
    model_paddle();
    check_pos("pad_rsvd");
  endtask

  task automatic test_spinner();
    spin_in[0] = {spin_in[0][8], 8'd100};
    spin_in[1] = {spin_in[1][8], 8'hFD};
    set_mode(2'd2, "spin_mode_change");
    cyc();
    check_pos("spin_idle");
    for (int i = 0; i < 3; i++) begin
      spin_flip();
      check_pos("spin_toggle");
    end
    spin_in[0][7:0] = 8'd50;
    spin_in[1][7:0] = 8'h80;
    cyc();
    check_pos("spin_no_toggle");
    cfg_invert = 1'b1;
    spin_flip();
    check_pos("spin_invert");
    cfg_invert = 1'b0;
    spin_flip();
    check_pos("spin_wrap");
  endtask

  task automatic test_mode_change_edge();
    joy_x[0] = 8'h40;
    joy_x[1] = 8'h00;
    set_mode(2'd0, "mc_to_joy");
    vb_pulse();
    check_pos("mc_joy_step");
    cfg_mode  = 2'd2;
    vblank    = 1'b1;
    rd_sel    = 2'd0;
    rd_strobe = 1'b1;
    q8.push_back(exp8[0]);
    q10.push_back(exp10[0]);
    cyc();
    rd_strobe = 1'b0;
    vblank    = 1'b0;
    set_center();
    check_pos("mc_priority");
    cyc();
    check_pos("mc_settled");
    set_mode(2'd0, "mc_back_joy");
    spin_in[0][8] = ~spin_in[0][8];
    cyc();
    check_pos("mc_joy_toggle");
    set_mode(2'd2, "mc_to_spin");
    cyc();
    check_pos("mc_no_stale_delta");
  endtask

  task automatic test_back_to_back();
    pad_in[0] = 8'h11;
    pad_in[1] = 8'h22;
    cfg_mode  = 2'd1;
    cyc();
    cyc();
    model_paddle();
    check_pos("b2b_paddle");
    rd(2'd0);
    rd(2'd1);
    rd(2'd2);
    rd(2'd1);
    cyc();
    check_no_valid("b2b_done");
  endtask

  task automatic test_reset_mid_read();
    rd_sel    = 2'd1;
    rd_strobe = 1'b1;
    reset     = 1'b1;
    cyc();
    rd_strobe = 1'b0;
    check_no_valid("reset_mid_read");
    cyc();
    reset = 1'b0;
    set_center();
    check_pos("reset_mid_read_pos");
    cyc();
    cyc();
    model_paddle();
    check_pos("after_reset_paddle");
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      joy_x[c]   = 8'h00;
      pad_in[c]  = 8'h00;
      spin_in[c] = 9'h000;
    end
    test_reset();
    test_joystick();
    test_deadzone();
    test_paddle();
    test_spinner();
    test_mode_change_edge();
    test_back_to_back();
    test_reset_mid_read();
    cyc();
    cyc();
    checks++;
    if (q8.size() != 0 || q10.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: got %0d/%0d outstanding, required 0/0", q8.size(), q10.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
